skew_feeder: RTL and testbench

Read-side sequencer for the 4x4 operand memory. It issues the diagonally skewed read pattern on the memory's `read_enable` / `read_elem` ports so that each memory column streams its elements into the systolic array one cycle after its left neighbour. A single `start` pulse launches one wavefront of `len+1` elements per column; `busy` and `done` report progress to the controller.

---
 rtl/skew_feeder_if.sv | 26 ++
 rtl/skew_feeder.sv | 90 +++++++++
 tb/tb_skew_feeder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/skew_feeder_if.sv
// Bundle between the operand-memory controller and the skew feeder: launch
// controls in, memory read pattern and progress flags out.
interface skew_feeder_if;
  // Handshake: start is a single-cycle request taken only while busy=0
  // (done cycle included); len is sampled on that same edge. There is no
  // back-pressure on the launch side; stall only freezes an active run.
  logic       start;
  logic [1:0] len;
  logic       stall;
  logic [3:0] read_enable;
  logic [7:0] read_elem;
  logic       busy;
  logic       done;
  logic [2:0] step;
  logic       state_dbg;

  modport master (
    output start, len, stall,
    input  read_enable, read_elem, busy, done, step, state_dbg
  );

  modport slave (
    input  start, len, stall,
    output read_enable, read_elem, busy, done, step, state_dbg
  );
endinterface

// File: rtl/skew_feeder.sv
// Read-side sequencer for the 4x4 operand memory: issues a diagonally skewed
// read pattern so each column streams one cycle after its left neighbour.
module skew_feeder #(
  parameter int COLS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  skew_feeder_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    FEED = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] t_q, t_d;
  logic [1:0] l_q, l_d;
  logic       done_q, done_d;
  logic [3:0] en;
  logic [7:0] elem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= 3'd0;
      l_q     <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      l_q     <= l_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    l_d     = l_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          l_d     = bus.len;
          t_d     = 3'd0;
          state_d = FEED;
        end
      end
      FEED: begin
        // The last step is column 3 reading element L, at t = L+3.
        if (!bus.stall) begin
          if (t_q == 3'(l_q) + 3'd3) begin
            state_d = IDLE;
            t_d     = 3'd0;
            done_d  = 1'b1;
          end else begin
            t_d = t_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        t_d     = 3'd0;
      end
    endcase
  end

  // Column c is live while c <= t <= c+L and reads element t-c.
  always_comb begin
    en   = '0;
    elem = '0;
    if (state_q == FEED) begin
      for (int c = 0; c < COLS; c++) begin
        if (t_q >= 3'(c) && t_q <= 3'(c) + 3'(l_q)) begin
          en[c]          = 1'b1;
          elem[2*c +: 2] = 2'(t_q - 3'(c));
        end
      end
    end
  end

  assign bus.read_enable = en;
  assign bus.read_elem   = elem;
  assign bus.busy        = (state_q == FEED);
  assign bus.done        = done_q;
  assign bus.step        = t_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_skew_feeder.sv
// Directed vector bench for skew_feeder: table of per-edge expectations plus
// a hand-written asynchronous-reset sequence.
module tb_skew_feeder;

  logic clk;
  logic rst_n;

  skew_feeder_if bus ();

  skew_feeder #(.COLS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       start;
    logic [1:0] len;
    logic       stall;
    logic [3:0] en;
    logic [7:0] elem;
    logic       busy;
    logic       done;
    logic [2:0] step;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_miss;

  function automatic vec_t mk(logic s, logic [1:0] l, logic st, logic [3:0] e,
                              logic [7:0] el, logic b, logic d, logic [2:0] t);
    vec_t v;
    v.start = s;  v.len = l;  v.stall = st;
    v.en = e;  v.elem = el;  v.busy = b;  v.done = d;  v.step = t;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [3:0] e, input logic [7:0] el,
                       input logic b, input logic d, input logic [2:0] t);
    n_vec++;
    if (bus.read_enable !== e || bus.read_elem !== el || bus.busy !== b ||
        bus.done !== d || bus.step !== t) begin
      n_miss++;
      $display("FAIL %s: got en=%b elem=%h busy=%b done=%b step=%0d, want en=%b elem=%h busy=%b done=%b step=%0d",
               name, bus.read_enable, bus.read_elem, bus.busy, bus.done, bus.step,
               e, el, b, d, t);
    end
  endtask

  // ---------------- driver ----------------
  task automatic apply_vec(input string name, input vec_t v);
    bus.start = v.start;
    bus.len   = v.len;
    bus.stall = v.stall;
    @(posedge clk);
    #1;
    check(name, v.en, v.elem, v.busy, v.done, v.step);
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.len   = 2'd0;
    bus.stall = 1'b0;

    // len=3, no stall (indices 0..8)
    vecs.push_back(mk(1, 3, 0, 4'b0001, 8'h00, 1, 0, 0));
    vecs.push_back(mk(0, 3, 0, 4'b0011, 8'h01, 1, 0, 1));
    vecs.push_back(mk(0, 3, 0, 4'b0111, 8'h06, 1, 0, 2));
    vecs.push_back(mk(0, 3, 0, 4'b1111, 8'h1B, 1, 0, 3));
    vecs.push_back(mk(0, 3, 0, 4'b1110, 8'h6C, 1, 0, 4));
    vecs.push_back(mk(0, 3, 0, 4'b1100, 8'hB0, 1, 0, 5));
    vecs.push_back(mk(0, 3, 0, 4'b1000, 8'hC0, 1, 0, 6));
    vecs.push_back(mk(0, 3, 0, 4'b0000, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 3, 0, 4'b0000, 8'h00, 0, 0, 0));
    // len=0
    vecs.push_back(mk(1, 0, 0, 4'b0001, 8'h00, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0010, 8'h00, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 4'b0100, 8'h00, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 4'b1000, 8'h00, 1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 8'h00, 0, 0, 0));
    // len=3 with a two-cycle stall at t=3
    vecs.push_back(mk(1, 3, 0, 4'b0001, 8'h00, 1, 0, 0));
    vecs.push_back(mk(0, 3, 0, 4'b0011, 8'h01, 1, 0, 1));
    vecs.push_back(mk(0, 3, 0, 4'b0111, 8'h06, 1, 0, 2));
    vecs.push_back(mk(0, 3, 0, 4'b1111, 8'h1B, 1, 0, 3));
    vecs.push_back(mk(0, 3, 1, 4'b1111, 8'h1B, 1, 0, 3));
    vecs.push_back(mk(0, 3, 1, 4'b1111, 8'h1B, 1, 0, 3));
    vecs.push_back(mk(0, 3, 0, 4'b1110, 8'h6C, 1, 0, 4));
    vecs.push_back(mk(0, 3, 0, 4'b1100, 8'hB0, 1, 0, 5));
    vecs.push_back(mk(0, 3, 0, 4'b1000, 8'hC0, 1, 0, 6));
    vecs.push_back(mk(0, 3, 0, 4'b0000, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 3, 0, 4'b0000, 8'h00, 0, 0, 0));
    // start ignored mid-run, then accepted in the done cycle with len=1
    vecs.push_back(mk(1, 3, 0, 4'b0001, 8'h00, 1, 0, 0));
    vecs.push_back(mk(0, 3, 0, 4'b0011, 8'h01, 1, 0, 1));
    vecs.push_back(mk(0, 3, 0, 4'b0111, 8'h06, 1, 0, 2));
    vecs.push_back(mk(1, 0, 0, 4'b1111, 8'h1B, 1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 4'b1110, 8'h6C, 1, 0, 4));
    vecs.push_back(mk(0, 0, 0, 4'b1100, 8'hB0, 1, 0, 5));
    vecs.push_back(mk(0, 0, 0, 4'b1000, 8'hC0, 1, 0, 6));
    vecs.push_back(mk(0, 0, 0, 4'b0000, 8'h00, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 4'b0001, 8'h00, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0011, 8'h01, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 4'b0110, 8'h04, 1, 0, 2));
    vecs.push_back(mk(0, 1, 0, 4'b1100, 8'h10, 1, 0, 3));
    vecs.push_back(mk(0, 1, 0, 4'b1000, 8'h40, 1, 0, 4));
    vecs.push_back(mk(0, 1, 0, 4'b0000, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 4'b0000, 8'h00, 0, 0, 0));
    // len=2 sampled at start, len wiggling afterwards
    vecs.push_back(mk(1, 2, 0, 4'b0001, 8'h00, 1, 0, 0));
    vecs.push_back(mk(0, 3, 0, 4'b0011, 8'h01, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 4'b0111, 8'h06, 1, 0, 2));
    vecs.push_back(mk(0, 1, 0, 4'b1110, 8'h18, 1, 0, 3));
    vecs.push_back(mk(0, 3, 0, 4'b1100, 8'h60, 1, 0, 4));
    vecs.push_back(mk(0, 0, 0, 4'b1000, 8'h80, 1, 0, 5));
    vecs.push_back(mk(0, 3, 0, 4'b0000, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 2, 0, 4'b0000, 8'h00, 0, 0, 0));

    // reset values
    #1;
    check("reset", 4'b0000, 8'h00, 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle", 4'b0000, 8'h00, 0, 0, 0);

    // main table
    for (int i = 0; i < vecs.size(); i++)
      apply_vec($sformatf("vec[%0d]", i), vecs[i]);

    // asynchronous reset at t=4 of a len=3 run
    for (int i = 0; i <= 4; i++)
      apply_vec($sformatf("pre_rst[%0d]", i), vecs[i]);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_now", 4'b0000, 8'h00, 0, 0, 0);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("async_rst_held", 4'b0000, 8'h00, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("no_done_after_rst", 4'b0000, 8'h00, 0, 0, 0);
    for (int i = 0; i <= 8; i++)
      apply_vec($sformatf("post_rst[%0d]", i), vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
